// File: rtl/clmul_div_seq.sv
// Sequential GF(2)[x] long divider: dividend = clmul(q, b) ^ r, one bit per cycle.
// Define CLDIV_DIVZERO_EN for the err port and a one-cycle divide-by-zero bypass.
module clmul_div_seq #(
    parameter int AW = 8,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*AW-2:0] a,
    input  logic [AW-1:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*AW-2:0] q,
    output logic [AW-1:0]   r
`ifdef CLDIV_DIVZERO_EN
    ,
    output logic            err
`endif
);

    localparam int DW = 2*AW-1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] w_q, w_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] bsh;
    logic [AW-1:0] b_q;
    logic [CW-1:0] db_q, i_q;
    logic [CW-1:0] db_in, sh;
    logic          fire;

    always_comb begin
        db_in = '0;
        for (int k = 0; k < AW; k++) begin
            if (b[k]) db_in = CW'(k);
        end
    end

    // b==0 keeps the XOR disabled so the dividend passes through untouched
    always_comb begin
        sh    = i_q - db_q;
        fire  = (b_q != '0) && (i_q >= db_q) && w_q[i_q];
        bsh   = {{(DW-AW){1'b0}}, b_q} << sh;
        w_d   = w_q;
        quo_d = quo_q;
        if (fire) begin
            w_d       = w_q ^ bsh;
            quo_d[sh] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            w_q       <= '0;
            quo_q     <= '0;
            b_q       <= '0;
            db_q      <= '0;
            i_q       <= '0;
`ifdef CLDIV_DIVZERO_EN
            err       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q      <= a;
                        b_q      <= b;
                        db_q     <= db_in;
                        quo_q    <= '0;
                        i_q      <= CW'(DW-1);
                        in_ready <= 1'b0;
`ifdef CLDIV_DIVZERO_EN
                        if (b == '0) begin
                            state_q   <= DONE;
                            out_valid <= 1'b1;
                            q         <= '0;
                            r         <= a[AW-1:0];
                            err       <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
`else
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    w_q   <= w_d;
                    quo_q <= quo_d;
                    if (i_q == '0) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                        q         <= quo_d;
                        r         <= w_d[AW-1:0];
                    end else begin
                        i_q <= i_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef CLDIV_DIVZERO_EN
                        err       <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clmul_div_seq.sv
// Scoreboard bench for clmul_div_seq: random jobs built as clmul(x,b)^rem.
// Directed cases cover reference values, back-pressure and mid-job reset.
module tb_clmul_div_seq;

    localparam int AW = 8;
    localparam int CW = 4;
    localparam int DW = 2*AW-1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [AW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] q;
    logic [AW-1:0] r;
`ifdef CLDIV_DIVZERO_EN
    logic          err;
`endif

    clmul_div_seq #(.AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r)
`ifdef CLDIV_DIVZERO_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [AW-1:0] r;
        logic          err;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   bp_hold = 0;
    bit   seen = 0;
    bit   post_pop = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d",
                     name, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] clmul(logic [DW-1:0] x, logic [AW-1:0] y);
        logic [DW-1:0] p;
        logic [DW-1:0] yy;
        p  = '0;
        yy = {{(DW-AW){1'b0}}, y};
        for (int i = 0; i < DW; i++) begin
            if (x[i]) p = p ^ (yy << i);
        end
        return p;
    endfunction

    function automatic int deg(logic [AW-1:0] y);
        int d;
        d = -1;
        for (int k = 0; k < AW; k++) begin
            if (y[k]) d = k;
        end
        return d;
    endfunction

    // consumer / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            seen     = 1'b0;
            post_pop = 1'b0;
        end else begin
            if (post_pop) begin
                check("pop_out_valid_low", 32'(out_valid), 32'd0);
                check("pop_in_ready_high", 32'(in_ready), 32'd1);
                post_pop = 1'b0;
            end
            if (out_valid && bp_hold > 0) begin
                out_ready = 1'b0;
                bp_hold--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid) begin
                check("done_in_ready_low", 32'(in_ready), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output q=%0h r=%0h none expected",
                             q, r);
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        seen = 1'b1;
                    end
                    check("q", 32'(q), 32'(sb[0].q));
                    check("r", 32'(r), 32'(sb[0].r));
`ifdef CLDIV_DIVZERO_EN
                    check("err", 32'(err), 32'(sb[0].err));
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen     = 1'b0;
                        post_pop = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(logic [DW-1:0] aa, logic [AW-1:0] bb,
                        logic [DW-1:0] eq, logic [AW-1:0] er, bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.acc = cyc;
`ifdef CLDIV_DIVZERO_EN
            e.err = (bb == '0);
            e.lat = (bb == '0) ? 1 : DW;
`else
            e.err = 1'b0;
            e.lat = DW;
`endif
            sb.push_back(e);
        end
        in_valid = 1'b0;
        a = DW'($urandom);
        b = AW'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] x, aa;
        logic [AW-1:0] bb, rem;
        int            db, t;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        rst_n = 1'b1;

        send(15'h0080, 8'h03, 15'h007F, 8'h01, 1'b1);
        send(15'h5555, 8'hFF, 15'h00FF, 8'h00, 1'b1);
        send(15'h7FFF, 8'h80, 15'h00FF, 8'h7F, 1'b1);
        send(15'h1234, 8'h01, 15'h1234, 8'h00, 1'b1);
        send(15'h00A5, 8'h00, 15'h0000, 8'hA5, 1'b1);
        drain();

        // back-pressure with ignored offers
        bp_hold = 20;
        send(15'h0080, 8'h03, 15'h007F, 8'h01, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        a = 15'h7777;
        b = 8'h05;
        repeat (15) begin
            @(posedge clk);
            #1;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        send(15'h5555, 8'hFF, 15'h00FF, 8'h00, 1'b1);
        drain();

        // reset in the middle of a job
        send(15'h1234, 8'h03, 15'h0000, 8'h00, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_r", 32'(r), 32'd0);
        rst_n = 1'b1;
        send(15'h7FFF, 8'h80, 15'h00FF, 8'h7F, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 31) == 0) begin
                aa = DW'($urandom);
                send(aa, 8'h00, '0, aa[AW-1:0], 1'b1);
            end else begin
                bb  = AW'($urandom_range(1, 255));
                db  = deg(bb);
                x   = DW'($urandom) & DW'((1 << (DW - db)) - 1);
                rem = AW'($urandom) & AW'((1 << db) - 1);
                aa  = clmul(x, bb) ^ {{(DW-AW){1'b0}}, rem};
                send(aa, bb, x, rem, 1'b1);
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
